decode_stage_hs: RTL and testbench

//  Parametrised successor decode stage. Sits between fetch and execute. Decodes the opcode into a

---
 rtl/srv1_pkg.sv | 56 +++++
 rtl/decode_stage_hs_inst_decoder.sv | 32 +++
 rtl/decode_stage_hs.sv | 144 ++++++++++++++
 tb/tb_decode_stage_hs.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/srv1_pkg.sv
// Shared decode types: control word layout, immediate/writeback selectors,
// base opcodes and the per-opcode control words.
package srv1_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        REG_IN_ALU  = 2'd0,
        REG_IN_MEM  = 2'd1,
        REG_IN_PC4  = 2'd2,
        REG_IN_UIMM = 2'd3
    } reg_in_e;

    // alu_asel: 0=rs1 1=pc; alu_bsel: 0=rs2 1=imm; alu_modsel: funct bits select ALU op;
    // bus_lock: memory access; mem_mode: 1=store 0=load
    typedef struct packed {
        logic     alu_asel;
        logic     alu_bsel;
        logic     alu_modsel;
        imm_sel_e imm_sel;
        logic     jump;
        logic     branch;
        logic     bus_lock;
        logic     mem_mode;
        logic     reg_we;
        reg_in_e  reg_in;
    } ctr_word_t;

    localparam logic [6:0] OP_ARITH   = 7'b0110011;
    localparam logic [6:0] OP_ARITH_I = 7'b0010011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;

    //                                         asel  bsel  mod   imm     jmp   br    lock  mem   we    reg_in
    localparam ctr_word_t CTR_ARITH   = '{1'b0, 1'b0, 1'b1, IMM_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, REG_IN_ALU};
    localparam ctr_word_t CTR_ARITH_I = '{1'b0, 1'b1, 1'b1, IMM_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, REG_IN_ALU};
    localparam ctr_word_t CTR_LOAD    = '{1'b0, 1'b1, 1'b0, IMM_I, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, REG_IN_MEM};
    localparam ctr_word_t CTR_STORE   = '{1'b0, 1'b1, 1'b0, IMM_S, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, REG_IN_ALU};
    localparam ctr_word_t CTR_BRANCH  = '{1'b1, 1'b1, 1'b0, IMM_B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, REG_IN_ALU};
    localparam ctr_word_t CTR_JAL     = '{1'b1, 1'b1, 1'b0, IMM_J, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, REG_IN_PC4};
    localparam ctr_word_t CTR_JALR    = '{1'b0, 1'b1, 1'b0, IMM_I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, REG_IN_PC4};
    localparam ctr_word_t CTR_LUI     = '{1'b0, 1'b1, 1'b0, IMM_U, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, REG_IN_UIMM};
    localparam ctr_word_t CTR_AUIPC   = '{1'b1, 1'b1, 1'b0, IMM_U, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, REG_IN_ALU};

endpackage

// File: rtl/decode_stage_hs_inst_decoder.sv
// Combinational opcode decoder: control word, source-register usage and illegal flag.
module inst_decoder
    import srv1_pkg::*;
(
    input  logic [31:0] inst,
    output ctr_word_t   ctr_word,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        illegal
);

    // Full 7-bit compare also rejects encodings whose low two bits are not 2'b11
    always_comb begin
        ctr_word = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (inst[6:0])
            OP_ARITH:   begin ctr_word = CTR_ARITH;   uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_ARITH_I: begin ctr_word = CTR_ARITH_I; uses_rs1 = 1'b1; end
            OP_LOAD:    begin ctr_word = CTR_LOAD;    uses_rs1 = 1'b1; end
            OP_STORE:   begin ctr_word = CTR_STORE;   uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_BRANCH:  begin ctr_word = CTR_BRANCH;  uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_JAL:     begin ctr_word = CTR_JAL; end
            OP_JALR:    begin ctr_word = CTR_JALR;    uses_rs1 = 1'b1; end
            OP_LUI:     begin ctr_word = CTR_LUI; end
            OP_AUIPC:   begin ctr_word = CTR_AUIPC; end
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage_hs.sv
// Decode stage with valid/ready handshakes on both sides: decodes the instruction,
// reads rs1/rs2 with writeback bypass, inserts load-use bubbles and registers the ID/EX state.
module decode_stage_hs
    import srv1_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PC_W      = 30,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            sync_rst,
    input  logic            clk_en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_in,
    input  logic [PC_W-1:0] pc_in,
    input  logic            invalidate,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     inst_out,
    output logic [PC_W-1:0] pc_out,
    output ctr_word_t       ctr_word_out,
    output logic [XLEN-1:0] rs1_out,
    output logic [XLEN-1:0] rs2_out,
    output logic            illegal_out
);

    logic            out_valid_reg;
    logic [31:0]     inst_out_reg;
    logic [PC_W-1:0] pc_out_reg;
    ctr_word_t       ctr_reg;
    logic            illegal_reg;

    ctr_word_t       dec_ctr;
    logic            dec_uses_rs1;
    logic            dec_uses_rs2;
    logic            dec_illegal;

    logic [XLEN-1:0] regs [NREGS];

    logic            hold;
    logic            hazard;
    logic            accept;
    logic [AW-1:0]   rd_ex;

    inst_decoder u_dec (
        .inst     (inst_in),
        .ctr_word (dec_ctr),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .illegal  (dec_illegal)
    );

    // A held instruction keeps re-reading its own sources so late writebacks still land
    assign hold  = out_valid_reg & ~out_ready;
    assign rd_ex = inst_out_reg[7 +: AW];

    // Load in EX whose destination feeds a source the incoming instruction actually uses
    assign hazard = out_valid_reg && (ctr_reg == CTR_LOAD) && (rd_ex != '0) &&
                    ((dec_uses_rs1 && (rd_ex == inst_in[15 +: AW])) ||
                     (dec_uses_rs2 && (rd_ex == inst_in[20 +: AW])));

    assign in_ready = clk_en & ~invalidate & ~hazard & (~out_valid_reg | out_ready);
    assign accept   = in_valid & in_ready;

    // Register file write port; x0 is never written and contents are not reset
    always_ff @(posedge clk) begin
        if (clk_en && wb_we && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Two identical read ports: rs1 at inst[19:15], rs2 at inst[24:20]
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data_next;
            logic [XLEN-1:0] data_reg;

            assign addr = hold ? inst_out_reg[15 + 5*gi +: AW] : inst_in[15 + 5*gi +: AW];

            // x0 reads zero; same-cycle writeback wins over the stored value
            always_comb begin
                if (addr == '0) begin
                    data_next = '0;
                end else if ((BYPASS_EN != 0) && wb_we && (wb_rd == addr)) begin
                    data_next = wb_data;
                end else begin
                    data_next = regs[addr];
                end
            end

            // Operand register follows the read address every enabled cycle
            always_ff @(posedge clk) begin
                if (sync_rst) begin
                    data_reg <= '0;
                end else if (clk_en) begin
                    data_reg <= data_next;
                end
            end
        end
    endgenerate

    // ID/EX register: flush, accept, drain/bubble, otherwise hold
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            out_valid_reg <= 1'b0;
            inst_out_reg  <= '0;
            pc_out_reg    <= '0;
            ctr_reg       <= '0;
            illegal_reg   <= 1'b0;
        end else if (clk_en) begin
            if (invalidate) begin
                out_valid_reg <= 1'b0;
                ctr_reg       <= '0;
                illegal_reg   <= 1'b0;
            end else if (accept) begin
                out_valid_reg <= 1'b1;
                inst_out_reg  <= inst_in;
                pc_out_reg    <= pc_in;
                ctr_reg       <= dec_ctr;
                illegal_reg   <= dec_illegal;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
                ctr_reg       <= '0;
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign inst_out     = inst_out_reg;
    assign pc_out       = pc_out_reg;
    assign ctr_word_out = ctr_reg;
    assign illegal_out  = illegal_reg;
    assign rs1_out      = g_rd[0].data_reg;
    assign rs2_out      = g_rd[1].data_reg;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: reset, plain decode, bypass, load-use,
// backpressure, freeze, flush and illegal opcodes.
module tb_decode_stage_hs;

    logic        clk = 1'b0;
    logic        sync_rst;
    logic        clk_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst_in;
    logic [29:0] pc_in;
    logic        invalidate;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_out;
    logic [29:0] pc_out;
    logic [12:0] ctr_word_out;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;
    logic        illegal_out;

    int total = 0;
    int bad   = 0;

    localparam logic [12:0] W_ARITH = 13'h0404;
    localparam logic [12:0] W_LOAD  = 13'h0815;

    localparam logic [31:0] I_ADD   = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_ADDX0 = 32'h002001B3; // add x3,x0,x2
    localparam logic [31:0] I_LW    = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h00528333; // add x6,x5,x5
    localparam logic [31:0] I_BAD   = 32'h0000007F;
    localparam logic [31:0] I_LOW01 = 32'h002081B1; // add with low bits 2'b01

    always #5 clk = ~clk;

    decode_stage_hs dut (
        .clk          (clk),
        .sync_rst     (sync_rst),
        .clk_en       (clk_en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inst_in      (inst_in),
        .pc_in        (pc_in),
        .invalidate   (invalidate),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .inst_out     (inst_out),
        .pc_out       (pc_out),
        .ctr_word_out (ctr_word_out),
        .rs1_out      (rs1_out),
        .rs2_out      (rs2_out),
        .illegal_out  (illegal_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("  ok %s = 0x%08h", tag, obs);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input logic [29:0] pc);
        in_valid = 1'b1;
        inst_in  = inst;
        pc_in    = pc;
    endtask

    initial begin
        sync_rst = 1'b1; clk_en = 1'b1; in_valid = 1'b0; inst_in = '0; pc_in = '0;
        invalidate = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;

        // 1. reset held two cycles, then idle
        step(); step();
        sync_rst = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst ctr", 32'(ctr_word_out), 32'd0);
        check("rst illegal", 32'(illegal_out), 32'd0);
        check("rst inst", inst_out, 32'd0);
        check("rst pc", 32'(pc_out), 32'd0);
        check("rst rs1", rs1_out, 32'd0);
        check("rst rs2", rs2_out, 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);

        // preload x1=5, x2=7 through the writeback port
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd5; step();
        wb_rd = 5'd2; wb_data = 32'd7; step();
        wb_we = 1'b0;

        // 2. plain add
        present(I_ADD, 30'h100);
        #1 check("add in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("add out_valid", 32'(out_valid), 32'd1);
        check("add rs1", rs1_out, 32'd5);
        check("add rs2", rs2_out, 32'd7);
        check("add ctr", 32'(ctr_word_out), 32'(W_ARITH));
        check("add inst", inst_out, I_ADD);
        check("add pc", 32'(pc_out), 32'h100);
        check("add illegal", 32'(illegal_out), 32'd0);

        // 3. bypass from writeback, then no forwarding onto x0
        present(I_ADD, 30'h104);
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000DEAD;
        step();
        check("byp rs1", rs1_out, 32'h0000DEAD);
        check("byp rs2", rs2_out, 32'd7);
        present(I_ADDX0, 30'h108);
        wb_rd = 5'd0;
        step();
        wb_we = 1'b0;
        check("byp x0 rs1", rs1_out, 32'd0);
        check("byp x0 rs2", rs2_out, 32'd7);

        // 4. load-use: one stall cycle, one bubble
        present(I_LW, 30'h10C);
        #1 check("lw in_ready", 32'(in_ready), 32'd1);
        step();
        check("lw ctr", 32'(ctr_word_out), 32'(W_LOAD));
        present(I_ADD6, 30'h110);
        #1 check("lu in_ready stall", 32'(in_ready), 32'd0);
        step();
        check("lu bubble valid", 32'(out_valid), 32'd0);
        check("lu bubble ctr", 32'(ctr_word_out), 32'd0);
        check("lu in_ready resume", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("lu add valid", 32'(out_valid), 32'd1);
        check("lu add inst", inst_out, I_ADD6);

        // 5. backpressure with a writeback to a held source
        present(I_ADD, 30'h200);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1 check("bp in_ready", 32'(in_ready), 32'd0);
        check("bp rs2 c0", rs2_out, 32'd7);
        step();
        check("bp rs1 held read", rs1_out, 32'h0000DEAD);
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'd9;
        step();
        wb_we = 1'b0;
        check("bp rs2 bypass", rs2_out, 32'd9);
        check("bp inst", inst_out, I_ADD);
        check("bp pc", 32'(pc_out), 32'h200);
        check("bp ctr", 32'(ctr_word_out), 32'(W_ARITH));
        step();
        check("bp rs2 regfile", rs2_out, 32'd9);
        check("bp valid", 32'(out_valid), 32'd1);

        // 6a. freeze: nothing moves while clk_en=0
        out_ready = 1'b1; clk_en = 1'b0;
        present(I_LW, 30'h204);
        #1 check("frz in_ready", 32'(in_ready), 32'd0);
        step();
        check("frz valid", 32'(out_valid), 32'd1);
        check("frz inst", inst_out, I_ADD);
        clk_en = 1'b1;

        // 6b. flush
        invalidate = 1'b1;
        #1 check("flush in_ready", 32'(in_ready), 32'd0);
        step();
        invalidate = 1'b0; in_valid = 1'b0;
        check("flush valid", 32'(out_valid), 32'd0);
        check("flush ctr", 32'(ctr_word_out), 32'd0);

        // 6c. illegal opcodes pass through flagged
        present(I_BAD, 30'h300);
        step();
        check("ill valid", 32'(out_valid), 32'd1);
        check("ill flag", 32'(illegal_out), 32'd1);
        check("ill ctr", 32'(ctr_word_out), 32'd0);
        check("ill inst", inst_out, I_BAD);
        present(I_LOW01, 30'h304);
        step();
        check("low01 flag", 32'(illegal_out), 32'd1);
        present(I_ADD, 30'h308);
        step();
        in_valid = 1'b0;
        check("legal flag", 32'(illegal_out), 32'd0);
        check("legal ctr", 32'(ctr_word_out), 32'(W_ARITH));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
